// File: rtl/usb_pd_rx_ctrl_if.sv
// Signal bundle between the USB-PD RX protocol sequencer, the RX/TX PHYs and the upper layer.
// master = sequencer side, slave = PHY/upper-layer side.
interface usb_pd_rx_ctrl_if;
    logic       enable;
    logic       phy_en;
    logic       phy_busy;
    logic       phy_pkg_valid;
    logic       phy_crc_valid;
    logic [2:0] phy_msg_id;
    logic [2:0] phy_msg_num;
    logic [3:0] phy_msg_type;
    logic       tx_req;
    logic [2:0] tx_msg_id;
    logic [2:0] tx_msg_num;
    logic [3:0] tx_msg_type;
    logic       tx_done;
    logic       usr_tx_req;
    logic [2:0] usr_tx_id;
    logic [2:0] usr_tx_num;
    logic [3:0] usr_tx_type;
    logic       usr_tx_ack;
    logic       msg_valid;
    logic       msg_ready;
    logic       crc_err;
    logic       ack_err;

    modport master (
        input  enable, phy_busy, phy_pkg_valid, phy_crc_valid,
               phy_msg_id, phy_msg_num, phy_msg_type, tx_done,
               usr_tx_req, usr_tx_id, usr_tx_num, usr_tx_type, msg_ready,
        output phy_en, tx_req, tx_msg_id, tx_msg_num, tx_msg_type,
               usr_tx_ack, msg_valid, crc_err, ack_err
    );

    modport slave (
        output enable, phy_busy, phy_pkg_valid, phy_crc_valid,
               phy_msg_id, phy_msg_num, phy_msg_type, tx_done,
               usr_tx_req, usr_tx_id, usr_tx_num, usr_tx_type, msg_ready,
        input  phy_en, tx_req, tx_msg_id, tx_msg_num, tx_msg_type,
               usr_tx_ack, msg_valid, crc_err, ack_err
    );
endinterface

// File: rtl/usb_pd_rx_ctrl.sv
// USB-PD receive protocol sequencer: packet qualification, GoodCRC reply, CC arbitration, upstream delivery.
// Define USB_PD_RX_DUP_FILTER_EN to build the duplicate-MessageID filter and last-id register.
//   state   | meaning
//   IDLE    | disabled, RX PHY parked
//   LISTEN  | RX PHY enabled, waiting for packet or user request
//   CHECK   | latched packet classified
//   ACK     | GoodCRC transmission in progress
//   DELIVER | message offered upstream, RX PHY held off
//   UTX     | user transmission in progress
module usb_pd_rx_ctrl #(
    parameter int system_khz     = 200000,
    parameter int ack_timeout_us = 195
) (
    input logic               clock,
    input logic               nrst,
    usb_pd_rx_ctrl_if.master  bus
);
    localparam int TC = system_khz * ack_timeout_us / 1000;
    localparam int CW = $clog2(TC) + 1;
    localparam logic [CW-1:0] TC_M1 = CW'(TC - 1);

    typedef enum logic [2:0] {IDLE, LISTEN, CHECK, ACK, DELIVER, UTX} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] tmr_q, tmr_d;
    logic [2:0]    rx_id_q, rx_id_d, rx_num_q, rx_num_d;
    logic [3:0]    rx_type_q, rx_type_d;
    logic          tx_req_q, tx_req_d;
    logic [2:0]    tx_id_q, tx_id_d, tx_num_q, tx_num_d;
    logic [3:0]    tx_type_q, tx_type_d;
    logic          usr_ack_q, usr_ack_d, crc_err_q, crc_err_d, ack_err_q, ack_err_d;
    logic          is_gcrc, dup, timeout;
`ifdef USB_PD_RX_DUP_FILTER_EN
    logic [2:0]    last_id_q, last_id_d;
    logic          last_vld_q, last_vld_d;
    logic          is_srst;
`endif

    always_comb begin
        state_d   = state_q;
        rx_id_d   = rx_id_q;
        rx_num_d  = rx_num_q;
        rx_type_d = rx_type_q;
        tx_req_d  = tx_req_q;
        tx_id_d   = tx_id_q;
        tx_num_d  = tx_num_q;
        tx_type_d = tx_type_q;
        usr_ack_d = 1'b0;
        crc_err_d = 1'b0;
        ack_err_d = 1'b0;
        is_gcrc   = (rx_type_q == 4'h1) && (rx_num_q == 3'd0);
        timeout   = (tmr_q == '0);
`ifdef USB_PD_RX_DUP_FILTER_EN
        last_id_d  = last_id_q;
        last_vld_d = last_vld_q;
        is_srst    = (rx_type_q == 4'hD) && (rx_num_q == 3'd0);
        dup        = last_vld_q && (last_id_q == rx_id_q);
`else
        dup        = 1'b0;
`endif

        case (state_q)
            IDLE: if (bus.enable) state_d = LISTEN;
            LISTEN: begin
                if (bus.phy_pkg_valid) begin
                    if (bus.phy_crc_valid) begin
                        rx_id_d   = bus.phy_msg_id;
                        rx_num_d  = bus.phy_msg_num;
                        rx_type_d = bus.phy_msg_type;
                        state_d   = CHECK;
                    end else begin
                        crc_err_d = 1'b1;
                    end
                end else if (bus.usr_tx_req && !bus.phy_busy) begin
                    tx_id_d   = bus.usr_tx_id;
                    tx_num_d  = bus.usr_tx_num;
                    tx_type_d = bus.usr_tx_type;
                    tx_req_d  = 1'b1;
                    state_d   = UTX;
                end
            end
            CHECK: begin
`ifdef USB_PD_RX_DUP_FILTER_EN
                if (is_srst) last_vld_d = 1'b0;
`endif
                if (is_gcrc) begin
                    state_d = DELIVER;
                end else begin
                    tx_id_d   = rx_id_q;
                    tx_num_d  = 3'd0;
                    tx_type_d = 4'h1;
                    tx_req_d  = 1'b1;
                    state_d   = ACK;
                end
            end
            ACK: begin
                if (bus.tx_done) begin
                    tx_req_d = 1'b0;
                    if (dup) begin
                        state_d = LISTEN;
                    end else begin
`ifdef USB_PD_RX_DUP_FILTER_EN
                        // Soft_Reset restarts the sender's id sequence, so leave the filter disarmed.
                        if (!is_srst) begin
                            last_id_d  = rx_id_q;
                            last_vld_d = 1'b1;
                        end
`endif
                        state_d = DELIVER;
                    end
                end else if (timeout) begin
                    tx_req_d  = 1'b0;
                    ack_err_d = 1'b1;
                    state_d   = LISTEN;
                end
            end
            DELIVER: if (bus.msg_ready) state_d = LISTEN;
            UTX: begin
                if (bus.tx_done) begin
                    tx_req_d  = 1'b0;
                    usr_ack_d = 1'b1;
                    state_d   = LISTEN;
                end else if (timeout) begin
                    tx_req_d  = 1'b0;
                    ack_err_d = 1'b1;
                    state_d   = LISTEN;
                end
            end
            default: state_d = IDLE;
        endcase

        if (!bus.enable) begin
            state_d   = IDLE;
            tx_req_d  = 1'b0;
            usr_ack_d = 1'b0;
            crc_err_d = 1'b0;
            ack_err_d = 1'b0;
`ifdef USB_PD_RX_DUP_FILTER_EN
            last_id_d  = last_id_q;
            last_vld_d = last_vld_q;
`endif
        end

        // Timeout down-counter reloads on every state change.
        if (state_d != state_q)  tmr_d = TC_M1;
        else if (tmr_q != '0)    tmr_d = tmr_q - 1'b1;
        else                     tmr_d = tmr_q;
    end

    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            state_q   <= IDLE;
            tmr_q     <= '0;
            rx_id_q   <= '0;
            rx_num_q  <= '0;
            rx_type_q <= '0;
            tx_req_q  <= 1'b0;
            tx_id_q   <= '0;
            tx_num_q  <= '0;
            tx_type_q <= '0;
            usr_ack_q <= 1'b0;
            crc_err_q <= 1'b0;
            ack_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            rx_id_q   <= rx_id_d;
            rx_num_q  <= rx_num_d;
            rx_type_q <= rx_type_d;
            tx_req_q  <= tx_req_d;
            tx_id_q   <= tx_id_d;
            tx_num_q  <= tx_num_d;
            tx_type_q <= tx_type_d;
            usr_ack_q <= usr_ack_d;
            crc_err_q <= crc_err_d;
            ack_err_q <= ack_err_d;
        end
    end

`ifdef USB_PD_RX_DUP_FILTER_EN
    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            last_id_q  <= '0;
            last_vld_q <= 1'b0;
        end else begin
            last_id_q  <= last_id_d;
            last_vld_q <= last_vld_d;
        end
    end
`endif

    assign bus.phy_en      = (state_q == LISTEN);
    assign bus.msg_valid   = (state_q == DELIVER);
    assign bus.tx_req      = tx_req_q;
    assign bus.tx_msg_id   = tx_id_q;
    assign bus.tx_msg_num  = tx_num_q;
    assign bus.tx_msg_type = tx_type_q;
    assign bus.usr_tx_ack  = usr_ack_q;
    assign bus.crc_err     = crc_err_q;
    assign bus.ack_err     = ack_err_q;
endmodule

// File: tb/tb_usb_pd_rx_ctrl.sv
// Scoreboard bench for usb_pd_rx_ctrl: stimulus pushes expected events, a negedge monitor pops and compares.
module tb_usb_pd_rx_ctrl;
    localparam int TC = 39000;

    logic clock = 1'b0;
    logic nrst  = 1'b0;
    always #5 clock = ~clock;

    usb_pd_rx_ctrl_if bus();
    usb_pd_rx_ctrl #(.system_khz(200000), .ack_timeout_us(195)) dut (
        .clock(clock), .nrst(nrst), .bus(bus)
    );

    typedef enum int {EV_TX, EV_MSG, EV_CRC, EV_AERR, EV_UACK} ev_kind_t;
    typedef struct {
        ev_kind_t   kind;
        logic [2:0] id;
        logic [2:0] num;
        logic [3:0] typ;
        int         at;
    } ev_t;

    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  cyc   = 0;
    logic p_tx = 0, p_mv = 0, p_crc = 0, p_aerr = 0, p_uack = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(string nm, int act, int expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    task automatic push(ev_kind_t k, logic [2:0] id, logic [2:0] num, logic [3:0] typ, int at);
        ev_t e;
        e.kind = k; e.id = id; e.num = num; e.typ = typ; e.at = at;
        exp_q.push_back(e);
    endtask

    task automatic observe(ev_kind_t k, logic [2:0] id, logic [2:0] num, logic [3:0] typ);
        ev_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_event: got %s id=%0d num=%0d type=%0h at cycle %0d, expected none",
                     k.name(), id, num, typ, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || (k == EV_TX && (e.id != id || e.num != num || e.typ != typ)) ||
                (e.at >= 0 && e.at != cyc)) begin
                n_bad++;
                $display("FAIL event: got %s id=%0d num=%0d type=%0h cycle=%0d, expected %s id=%0d num=%0d type=%0h cycle=%0d",
                         k.name(), id, num, typ, cyc, e.kind.name(), e.id, e.num, e.typ, e.at);
            end
        end
    endtask

    task automatic pulse_chk(string nm, logic now, logic prev);
        if (now && prev) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_width: got >1 cycle, expected 1 cycle (cycle %0d)", nm, cyc);
        end
    endtask

    always @(negedge clock) begin
        if (nrst) begin
            chk("phy_en_exclusive", int'(bus.phy_en && (bus.msg_valid || bus.tx_req)), 0);
            if (bus.tx_req && !p_tx)
                observe(EV_TX, bus.tx_msg_id, bus.tx_msg_num, bus.tx_msg_type);
            if (bus.msg_valid && !p_mv)     observe(EV_MSG, 3'd0, 3'd0, 4'd0);
            if (bus.crc_err && !p_crc)      observe(EV_CRC, 3'd0, 3'd0, 4'd0);
            if (bus.ack_err && !p_aerr)     observe(EV_AERR, 3'd0, 3'd0, 4'd0);
            if (bus.usr_tx_ack && !p_uack)  observe(EV_UACK, 3'd0, 3'd0, 4'd0);
            pulse_chk("crc_err", bus.crc_err, p_crc);
            pulse_chk("ack_err", bus.ack_err, p_aerr);
            pulse_chk("usr_tx_ack", bus.usr_tx_ack, p_uack);
        end
        p_tx = bus.tx_req; p_mv = bus.msg_valid; p_crc = bus.crc_err;
        p_aerr = bus.ack_err; p_uack = bus.usr_tx_ack;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Expected reaction to a received packet is pushed here.
    task automatic rx_pkt(logic [2:0] id, logic [2:0] num, logic [3:0] typ, logic crc);
        bus.phy_msg_id = id; bus.phy_msg_num = num; bus.phy_msg_type = typ;
        bus.phy_crc_valid = crc; bus.phy_pkg_valid = 1'b1;
        if (!crc)                           push(EV_CRC, 0, 0, 0, cyc + 1);
        else if (typ == 4'h1 && num == 3'd0) push(EV_MSG, 0, 0, 0, cyc + 2);
        else                                push(EV_TX, id, 3'd0, 4'h1, cyc + 2);
        tick();
        bus.phy_pkg_valid = 1'b0;
        bus.phy_crc_valid = 1'b0;
    endtask

    task automatic wait_tx();
        int n = 0;
        while (!bus.tx_req && n < 10) begin tick(); n++; end
        chk("tx_req_seen", int'(bus.tx_req), 1);
    endtask

    // what: 0 none expected, 1 delivery, 2 user ack
    task automatic send_done(int what);
        bus.tx_done = 1'b1;
        if (what == 1) push(EV_MSG, 0, 0, 0, cyc + 1);
        if (what == 2) push(EV_UACK, 0, 0, 0, cyc + 1);
        tick();
        bus.tx_done = 1'b0;
    endtask

    task automatic accept(string nm);
        chk({nm, "_msg_valid"}, int'(bus.msg_valid), 1);
        bus.msg_ready = 1'b1;
        tick();
        bus.msg_ready = 1'b0;
        chk({nm, "_msg_valid_fall"}, int'(bus.msg_valid), 0);
        chk({nm, "_phy_en_back"}, int'(bus.phy_en), 1);
    endtask

    task automatic rx_acked(logic [2:0] id, logic [3:0] typ, int what, string nm);
        rx_pkt(id, 3'd0, typ, 1'b1);
        wait_tx();
        repeat (9) tick();
        send_done(what);
        if (what == 1) accept(nm);
    endtask

    initial begin
        int t0;
        int n;
        bus.enable = 0; bus.phy_busy = 0; bus.phy_pkg_valid = 0; bus.phy_crc_valid = 0;
        bus.phy_msg_id = 0; bus.phy_msg_num = 0; bus.phy_msg_type = 0; bus.tx_done = 0;
        bus.usr_tx_req = 0; bus.usr_tx_id = 0; bus.usr_tx_num = 0; bus.usr_tx_type = 0;
        bus.msg_ready = 0;
        repeat (3) tick();
        chk("rst_phy_en", int'(bus.phy_en), 0);
        chk("rst_tx_req", int'(bus.tx_req), 0);
        chk("rst_msg_valid", int'(bus.msg_valid), 0);
        chk("rst_pulses", int'({bus.crc_err, bus.ack_err, bus.usr_tx_ack}), 0);
        chk("rst_tx_fields", int'({bus.tx_msg_id, bus.tx_msg_num, bus.tx_msg_type}), 0);
        nrst = 1'b1;
        tick();
        chk("idle_phy_en", int'(bus.phy_en), 0);
        bus.enable = 1'b1;
        tick();
        chk("listen_phy_en", int'(bus.phy_en), 1);

        // Request_1: PS_RDY id 3
        rx_pkt(3'd3, 3'd0, 4'h6, 1'b1);
        chk("check_phy_en", int'(bus.phy_en), 0);
        wait_tx();
        repeat (9) tick();
        send_done(1);
        repeat (2) tick();
        chk("deliver_held", int'(bus.msg_valid), 1);
        accept("req1");

        // Duplicate id 3
`ifdef USB_PD_RX_DUP_FILTER_EN
        rx_acked(3'd3, 4'h6, 0, "dup");
        chk("dup_no_deliver", int'(bus.msg_valid), 0);
        chk("dup_listen", int'(bus.phy_en), 1);
`else
        rx_acked(3'd3, 4'h6, 1, "dup");
`endif

        // Soft_Reset id 3 then message id 3, both delivered
        rx_acked(3'd3, 4'hD, 1, "srst");
        rx_acked(3'd3, 4'h6, 1, "after_srst");

        // Received GoodCRC: delivered without reply
        rx_pkt(3'd0, 3'd0, 4'h1, 1'b1);
        tick();
        accept("goodcrc");

        // CRC failure
        rx_pkt(3'd4, 3'd2, 4'h6, 1'b0);
        repeat (3) tick();
        chk("crc_stay_listen", int'(bus.phy_en), 1);
        chk("crc_no_tx", int'(bus.tx_req), 0);

        // Reply timeout
        rx_pkt(3'd5, 3'd0, 4'h6, 1'b1);
        wait_tx();
        t0 = cyc;
        push(EV_AERR, 0, 0, 0, -1);
        n = 0;
        while (bus.tx_req && n < TC + 100) begin tick(); n++; end
        chk("timeout_tx_req_low", int'(bus.tx_req), 0);
        chk("timeout_len_ok", int'((cyc - t0) >= TC - 1 && (cyc - t0) <= TC + 1), 1);
        chk("timeout_ack_err", int'(bus.ack_err), 1);
        chk("timeout_listen", int'(bus.phy_en), 1);
        chk("timeout_no_deliver", int'(bus.msg_valid), 0);
        rx_acked(3'd5, 4'h6, 1, "id5_after_timeout");

        // enable drop during ACK
        rx_pkt(3'd7, 3'd0, 4'h6, 1'b1);
        wait_tx();
        tick();
        bus.enable = 1'b0;
        tick();
        chk("disable_tx_req", int'(bus.tx_req), 0);
        chk("disable_phy_en", int'(bus.phy_en), 0);
        send_done(0);
        repeat (2) tick();
        bus.enable = 1'b1;
        repeat (2) tick();
        chk("reenable_listen", int'(bus.phy_en), 1);
        send_done(0);
        bus.msg_ready = 1'b1;
        repeat (3) tick();
        bus.msg_ready = 1'b0;
        chk("ready_idle_no_msg", int'(bus.msg_valid), 0);

        // User request blocked by busy RX, served after delivery
        bus.phy_busy = 1'b1;
        bus.usr_tx_req = 1'b1; bus.usr_tx_id = 3'd2; bus.usr_tx_num = 3'd1; bus.usr_tx_type = 4'h3;
        repeat (5) tick();
        chk("busy_blocks_user", int'(bus.tx_req), 0);
        bus.phy_busy = 1'b0;
        rx_pkt(3'd6, 3'd0, 4'h6, 1'b1);
        wait_tx();
        repeat (3) tick();
        send_done(1);
        repeat (3) tick();
        chk("deliver_blocks_user", int'(bus.tx_req), 0);
        push(EV_TX, 3'd2, 3'd1, 4'h3, cyc + 2);
        accept("busy_msg");
        tick();
        chk("user_tx_req", int'(bus.tx_req), 1);
        bus.usr_tx_req = 1'b0;
        repeat (4) tick();
        send_done(2);
        tick();
        chk("user_done_listen", int'(bus.phy_en), 1);

        repeat (5) tick();
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/usb_pd_rx_ctrl.md
# usb_pd_rx_ctrl

Protocol-layer sequencer for the USB-PD receive PHY. It enables and parks `usb_pd_phy_rd`, qualifies each received packet (CRC, duplicate MessageID, Soft_Reset), and commands the TX PHY to answer with GoodCRC. It also arbitrates the shared CC line between automatic GoodCRC replies and upper-layer transmit requests, and hands accepted messages upstream with a valid/ready handshake. While a delivered message is pending, the RX PHY is held disabled so its header and word outputs stay stable for the consumer.

## Interface
- `system_khz`, 200000: system clock frequency in kHz.
- `ack_timeout_us`, 195: maximum wait for `tx_done` after `tx_req` (tTransmit).
- `clock` in 1: system clock, rising edge.
- `nrst` in 1: reset, asynchronous, active-low.
- `enable` in 1: controller enable; low forces IDLE.
- `phy_en` out 1: drives the RX PHY `enable`.
- `phy_busy` in 1: RX PHY `busy`.
- `phy_pkg_valid` in 1: RX PHY one-cycle packet-done pulse.
- `phy_crc_valid` in 1: RX PHY CRC good, sampled with `phy_pkg_valid`.
- `phy_msg_id` in 3: RX PHY MessageID.
- `phy_msg_num` in 3: RX PHY data-object count.
- `phy_msg_type` in 4: RX PHY message type.
- `tx_req` out 1: TX PHY request, held until `tx_done`.
- `tx_msg_id` out 3: MessageID sent to the TX PHY.
- `tx_msg_num` out 3: data-object count sent to the TX PHY.
- `tx_msg_type` out 4: message type sent to the TX PHY.
- `tx_done` in 1: TX PHY one-cycle completion pulse.
- `usr_tx_req` in 1: upper-layer transmit request, level.
- `usr_tx_id` in 3: upper-layer MessageID.
- `usr_tx_num` in 3: upper-layer data-object count.
- `usr_tx_type` in 4: upper-layer message type.
- `usr_tx_ack` out 1: one-cycle pulse when the user transmission completes.
- `msg_valid` out 1: received message available upstream.
- `msg_ready` in 1: upstream accepts the message.
- `crc_err` out 1: one-cycle pulse on a CRC-failed packet.
- `ack_err` out 1: one-cycle pulse on a TX timeout.

## Operation
- States:
  - IDLE: `phy_en`=0.
  - LISTEN: `phy_en`=1.
  - CHECK.
  - ACK: GoodCRC TX in progress.
  - DELIVER.
  - UTX: user TX in progress.
- IDLE→LISTEN when `enable`=1. Any state→IDLE the cycle after `enable` falls. Outstanding `tx_req` is dropped. No pulse is emitted.
- LISTEN, `phy_pkg_valid`=1:
  - Latch `phy_msg_id`, `phy_msg_num`, `phy_msg_type` and go to CHECK. `phy_en` falls on entry to CHECK.
  - If `phy_crc_valid`=0, pulse `crc_err` and stay in LISTEN.
- LISTEN, `usr_tx_req`=1 and `phy_busy`=0: load `tx_*` from `usr_tx_*`, assert `tx_req`, go to UTX.
- LISTEN, simultaneous RX and user request: `phy_busy` or `phy_pkg_valid` wins and the user request waits.
- CHECK:
  - Received type 4'h1 with num 0 (GoodCRC): no ACK, go to DELIVER.
  - Otherwise load `tx_msg_type`=4'h1, `tx_msg_num`=0, `tx_msg_id`=latched id. Assert `tx_req` and go to ACK.
- Soft_Reset (type 4'hD, num 0): clears the stored last-id valid flag before the duplicate check.
- ACK, on `tx_done`:
  - Duplicate (filter on, last-id valid, latched id equals last id): go to LISTEN without delivering.
  - Otherwise store the latched id as last id, set it valid, go to DELIVER.
- DELIVER: `msg_valid`=1 and `phy_en`=0. On `msg_valid & msg_ready`, go to LISTEN.
- UTX, on `tx_done`: pulse `usr_tx_ack` and go to LISTEN.
- Timeout in ACK or UTX: if the counter reaches `system_khz*ack_timeout_us/1000` cycles without `tx_done`:
  - Pulse `ack_err`, drop `tx_req`, go to LISTEN.
  - From ACK, nothing is delivered and the last id is not updated.
- Counter width: `$clog2` of the terminal count plus 1. The counter clears on every state entry.

## Timing
- Reset values:
  - All outputs 0 and state IDLE.
  - Last id 0, last-id valid 0.
- `phy_pkg_valid` sampled in cycle N → CHECK in N+1 → `tx_req` high at N+2.
- `tx_req` and `tx_*` are stable from assertion until the cycle after `tx_done`.
- `tx_done` sampled in cycle M → `tx_req` low at M+1.
  - If a message is delivered, `msg_valid` is high at M+1.
- `msg_valid` and `phy_en` are mutually exclusive in every cycle.
- `usr_tx_ack`, `crc_err` and `ack_err` are exactly one cycle wide.
- `tx_done` outside ACK or UTX is ignored.
- `phy_pkg_valid` outside LISTEN is ignored.
- `msg_ready` held high with no message pending has no effect.

## Configuration
- `USB_PD_RX_DUP_FILTER_EN` defined: duplicate MessageID filtering and the last-id register are present.
- Undefined: every ACKed non-GoodCRC message is delivered. Soft_Reset handling is unchanged apart from having no register to clear.

## Test plan
- Request_1: PS_RDY (type 4'h6, id 3, num 0, CRC good), then `tx_done` 10 cycles after `tx_req` → `tx_req` at N+2 with type 4'h1, id 3, num 0. `msg_valid` rises after `tx_done` and falls the cycle after `msg_ready`. `phy_en` is 0 throughout.
- Duplicate id 3 resent (filter on) → GoodCRC is sent and `msg_valid` stays 0. With the macro undefined, `msg_valid`=1.
- Soft_Reset id 3, then message id 3 → both are delivered.
- CRC fail (`phy_crc_valid`=0) → `crc_err` pulse, no `tx_req`, state stays LISTEN.
- No `tx_done` for 39000 cycles at 200 MHz → `ack_err` pulse, `tx_req` falls, no delivery, LISTEN.
- `usr_tx_req` asserted while `phy_busy`=1 → no `tx_req` until the RX message is delivered. Then user `tx_*` is issued and `usr_tx_ack` pulses on `tx_done`.
